// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed, checksummed byte stream and
// writes it into program memory while holding the CPU core stalled.
//
// Stream format: LEN (1..DEPTH), LEN data bytes, CSUM.
// The load succeeds when (LEN + data bytes + CSUM) mod 256 == 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   one-cycle load request (honoured in IDLE/DONE/ERR)
//   rx_data    in   [7:0] incoming byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  byte accepted this cycle when rx_valid is also 1
//   pm_we      out  program memory write strobe (one cycle per data byte)
//   pm_addr    out  [4:0] program memory write address
//   pm_wdata   out  [7:0] program memory write data
//   cpu_hold   out  CPU stall while program memory is not known good
//   busy       out  load in progress
//   done       out  last load succeeded
//   error      out  last load failed
//   load_count out  [5:0] data bytes written in current/last load
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | after reset, waiting for start, CPU not held
// S_LEN  | waiting for the length byte
// S_DATA | receiving data bytes, each one written to program memory
// S_CSUM | waiting for the checksum byte
// S_DONE | load succeeded, CPU released
// S_ERR  | bad length, bad checksum or timeout; CPU stays held
module program_loader #(
  parameter int DEPTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       pm_we,
  output logic [4:0] pm_addr,
  output logic [7:0] pm_wdata,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [5:0] load_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  // Idle timer is a down-counter reloaded on every transfer; the timeout
  // fires in the cycle it would reach zero.
  localparam int            IW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 2) : 1;
  localparam logic [IW-1:0] IDLE_LOAD = IW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    DEPTH_B   = 8'(DEPTH);

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          we_q, we_d;
  logic [4:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;

  logic       in_load;
  logic       xfer;
  logic       timeout_hit;
  logic [7:0] sum_next;
  logic       last_data;

  assign in_load     = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign xfer        = rx_valid && in_load;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (idle_q == IW'(1));
  assign sum_next    = sum_q + rx_data;
  assign last_data   = ({2'b00, cnt_q} + 8'd1) == len_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          len_d   = 8'd0;
          sum_d   = 8'd0;
          cnt_d   = 6'd0;
          idle_d  = IDLE_LOAD;
        end
      end
      S_LEN: begin
        if (xfer) begin
          sum_d  = sum_next;
          idle_d = IDLE_LOAD;
          if ((rx_data == 8'd0) || (rx_data > DEPTH_B)) begin
            state_d = S_ERR;
          end else begin
            len_d   = rx_data;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[4:0];
          wdata_d = rx_data;
          cnt_d   = cnt_q + 6'd1;
          sum_d   = sum_next;
          idle_d  = IDLE_LOAD;
          if (last_data) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (sum_next == 8'd0) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // A transfer always wins over the timeout in the same cycle.
    if (in_load && !xfer) begin
      if (timeout_hit) begin
        state_d = S_ERR;
      end else if (TIMEOUT_CYCLES != 0) begin
        idle_d = idle_q - IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= 8'd0;
      sum_q   <= 8'd0;
      cnt_q   <= 6'd0;
      idle_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rx_ready   = in_load;
  assign busy       = in_load;
  assign cpu_hold   = in_load || (state_q == S_ERR);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign pm_we      = we_q;
  assign pm_addr    = addr_q;
  assign pm_wdata   = wdata_q;
  assign load_count = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int TO    = 4;
  localparam int DEPTH = 32;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       pm_we;
  logic [4:0] pm_addr;
  logic [7:0] pm_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [5:0] load_count;

  program_loader #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .load_count(load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 loading, 2 succeeded, 3 failed.
  // While loading, m_len < 0 means the length byte is still outstanding and
  // m_cnt == m_len means only the checksum remains.
  int m_mode = 0;
  int m_len  = -1;
  int m_cnt  = 0;
  int m_sum  = 0;
  int m_idle = 0;
  int e_we    = 0;
  int e_addr  = 0;
  int e_wdata = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_len = -1; m_cnt = 0; m_sum = 0; m_idle = 0;
      e_we = 0; e_addr = 0; e_wdata = 0;
    end else begin
      e_we = 0;
      if (m_mode == 1) begin
        if (rx_valid) begin
          m_idle = 0;
          if (m_len < 0) begin
            m_sum = (m_sum + int'(rx_data)) % 256;
            if (rx_data == 0 || int'(rx_data) > DEPTH) m_mode = 3;
            else m_len = int'(rx_data);
          end else if (m_cnt < m_len) begin
            e_we = 1; e_addr = m_cnt; e_wdata = int'(rx_data);
            m_cnt = m_cnt + 1;
            m_sum = (m_sum + int'(rx_data)) % 256;
          end else begin
            m_mode = (((m_sum + int'(rx_data)) % 256) == 0) ? 2 : 3;
          end
        end else begin
          m_idle = m_idle + 1;
          if (TO != 0 && m_idle >= TO) m_mode = 3;
        end
      end else if (start) begin
        m_mode = 1; m_len = -1; m_cnt = 0; m_sum = 0; m_idle = 0;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  logic [12:0] wr_log[$];
  logic [12:0] exp_w[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("rx_ready",   32'(rx_ready),   32'(m_mode == 1));
    chk("busy",       32'(busy),       32'(m_mode == 1));
    chk("cpu_hold",   32'(cpu_hold),   32'(m_mode == 1 || m_mode == 3));
    chk("done",       32'(done),       32'(m_mode == 2));
    chk("error",      32'(error),      32'(m_mode == 3));
    chk("pm_we",      32'(pm_we),      32'(e_we));
    chk("pm_addr",    32'(pm_addr),    32'(e_addr));
    chk("pm_wdata",   32'(pm_wdata),   32'(e_wdata));
    chk("load_count", 32'(load_count), 32'(m_cnt));
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_all();
    if (pm_we === 1'b1) wr_log.push_back({pm_addr, pm_wdata});
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic check_writes(input string name);
    chk({name, "_nwr"}, 32'(wr_log.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++)
      chk({name, "_wr"}, 32'(wr_log[i]), 32'(exp_w[i]));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    ticks(2);
    chk("rst_ready", 32'(rx_ready), 0);
    chk("rst_hold",  32'(cpu_hold), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(error), 0);
    chk("rst_we",    32'(pm_we), 0);
    chk("rst_cnt",   32'(load_count), 0);
    chk_en = 1;
    reset  = 1'b0;
    ticks(2);

    // Good load of three bytes.
    wr_log.delete();
    send_start();
    send_byte(8'h03); send_byte(8'h10); send_byte(8'h41); send_byte(8'h20); send_byte(8'h8C);
    ticks(2);
    chk("ok_done", 32'(done), 1);
    chk("ok_hold", 32'(cpu_hold), 0);
    chk("ok_err",  32'(error), 0);
    chk("ok_cnt",  32'(load_count), 3);
    chk("ok_model_mode", 32'(m_mode), 2);
    exp_w = '{{5'd0, 8'h10}, {5'd1, 8'h41}, {5'd2, 8'h20}};
    check_writes("ok");
    // Bytes in DONE are ignored.
    send_byte(8'h55);
    ticks(1);
    chk("done_ign_nwr", 32'(wr_log.size()), 3);
    chk("done_ign_done", 32'(done), 1);

    // Bad checksum.
    wr_log.delete();
    send_start();
    send_byte(8'h03); send_byte(8'h10); send_byte(8'h41); send_byte(8'h20); send_byte(8'h8D);
    ticks(2);
    chk("bad_err",  32'(error), 1);
    chk("bad_done", 32'(done), 0);
    chk("bad_hold", 32'(cpu_hold), 1);
    chk("bad_cnt",  32'(load_count), 3);
    check_writes("bad");

    // Illegal lengths 0 and DEPTH+1.
    wr_log.delete();
    send_start();
    send_byte(8'h00);
    chk("len0_err", 32'(error), 1);
    send_start();
    chk("restart_err", 32'(error), 0);
    chk("restart_busy", 32'(busy), 1);
    send_byte(8'h21);
    chk("len33_err", 32'(error), 1);
    ticks(1);
    chk("badlen_nwr", 32'(wr_log.size()), 0);

    // Timeout after one data byte.
    wr_log.delete();
    send_start();
    send_byte(8'h02); send_byte(8'h55);
    ticks(3);
    chk("to_pre_err",  32'(error), 0);
    chk("to_pre_busy", 32'(busy), 1);
    ticks(1);
    chk("to_err", 32'(error), 1);
    chk("to_cnt", 32'(load_count), 1);
    exp_w = '{{5'd0, 8'h55}};
    check_writes("to");

    // Transfer in the cycle the timeout would fire wins.
    wr_log.delete();
    send_start();
    send_byte(8'h01);
    ticks(3);
    send_byte(8'hAA);
    chk("tw_busy", 32'(busy), 1);
    ticks(3);
    send_byte(8'h55);
    ticks(1);
    chk("tw_done", 32'(done), 1);
    exp_w = '{{5'd0, 8'hAA}};
    check_writes("tw");

    // Reset mid-load with simultaneous start and transfer.
    wr_log.delete();
    send_start();
    send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
    reset = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'h33;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("mr_ready", 32'(rx_ready), 0);
    chk("mr_busy",  32'(busy), 0);
    chk("mr_hold",  32'(cpu_hold), 0);
    chk("mr_we",    32'(pm_we), 0);
    chk("mr_addr",  32'(pm_addr), 0);
    chk("mr_wdata", 32'(pm_wdata), 0);
    chk("mr_cnt",   32'(load_count), 0);
    rx_data = 8'h44;
    ticks(3);
    rx_valid = 1'b0;
    chk("mr_ign_ready", 32'(rx_ready), 0);
    exp_w = '{{5'd0, 8'h11}, {5'd1, 8'h22}};
    check_writes("mr");

    // Start during DATA ignored, rx_valid with gaps.
    wr_log.delete();
    send_start();
    rx_valid = 1'b1; rx_data = 8'h04; tick();
    rx_data = 8'h01; tick();
    rx_valid = 1'b0; tick();
    rx_valid = 1'b1; rx_data = 8'h02; start = 1'b1; tick();
    rx_valid = 1'b0; start = 1'b0; tick();
    start = 1'b1; tick();
    start = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h03; tick();
    rx_data = 8'h04; tick();
    rx_valid = 1'b0; tick();
    rx_valid = 1'b1; rx_data = 8'hF2; tick();
    rx_valid = 1'b0;
    ticks(2);
    chk("gap_done", 32'(done), 1);
    chk("gap_cnt",  32'(load_count), 4);
    exp_w = '{{5'd0, 8'h01}, {5'd1, 8'h02}, {5'd2, 8'h03}, {5'd3, 8'h04}};
    check_writes("gap");

    ticks(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL provide parameter DEPTH, default 32, meaning number of program memory words (addresses 0..DEPTH-1).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 255, meaning max idle cycles between accepted bytes during a load; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port rx_data  input  8  incoming byte.
REQ-007 SHALL have port rx_valid  input  1  rx_data valid.
REQ-008 SHALL have port rx_ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port pm_we  output  1  program memory write strobe.
REQ-010 SHALL have port pm_addr  output  5  program memory write address.
REQ-011 SHALL have port pm_wdata  output  8  program memory write data (one instruction byte).
REQ-012 SHALL have port cpu_hold  output  1  holds the CPU core stalled while program memory is invalid.
REQ-013 SHALL have ports busy, done, error  output  1 each  load in progress / load succeeded / load failed.
REQ-014 SHALL have port load_count  output  6  number of data bytes written in the current/last load.

Function
REQ-015 SHALL implement states IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-016 Byte transfer SHALL occur only in a cycle where rx_valid=1 and rx_ready=1; rx_ready SHALL be 1 exactly in LEN, DATA, CSUM.
REQ-017 start in IDLE, DONE or ERR SHALL move to LEN next cycle, clear done, error, load_count and the running sum, and set cpu_hold=1 and busy=1; start in LEN/DATA/CSUM SHALL be ignored.
REQ-018 LEN: accepted byte N SHALL be the length; 1 <= N <= DEPTH -> DATA; N=0 or N>DEPTH -> ERR; N SHALL be added to the running 8-bit sum.
REQ-019 DATA: k-th accepted byte (k=0..N-1) SHALL produce, in the following cycle, pm_we=1 for exactly one cycle with pm_addr=k and pm_wdata=byte; byte SHALL be added to running sum; load_count SHALL increment on acceptance; after byte N-1 -> CSUM.
REQ-020 pm_we SHALL be 0 in every cycle not specified by REQ-019; pm_addr/pm_wdata SHALL hold the last written values otherwise.
REQ-021 CSUM: accepted byte C -> DONE if (running sum + C) mod 256 = 0, else ERR.
REQ-022 Running sum SHALL be modulo 256 (carry discarded).
REQ-023 An idle counter SHALL count cycles in LEN/DATA/CSUM with no transfer, clear on each transfer and on entering LEN; reaching TIMEOUT_CYCLES (non-zero) SHALL force ERR next cycle.
REQ-024 DONE: cpu_hold=0, busy=0, done=1, held until start or reset.
REQ-025 ERR: cpu_hold=1, busy=0, error=1, held until start or reset; bytes already written SHALL NOT be undone.
REQ-026 A data byte accepted in the same cycle the timeout would fire SHALL be accepted (transfer wins over timeout).
REQ-027 Bytes presented with rx_valid=1 in IDLE, DONE or ERR SHALL be ignored (rx_ready=0).
REQ-028 The final pm_we pulse of a load SHALL occur in the cycle the FSM enters CSUM, i.e. before done can assert.

Reset
REQ-029 reset=1 at a clock edge SHALL, from any state including mid-load, force IDLE with rx_ready=0, pm_we=0, pm_addr=0, pm_wdata=0, cpu_hold=0, busy=0, done=0, error=0, load_count=0, sum and idle counter=0.
REQ-030 reset SHALL take priority over start and over any simultaneous transfer.

Verification
REQ-031 start; bytes 0x03, 0x10, 0x41, 0x20, 0x8C (sum 0x100) -> writes (0,0x10),(1,0x41),(2,0x20), one pm_we each; done=1, cpu_hold=0, load_count=3.
REQ-032 Same stream with checksum 0x8D -> three writes occur, error=1, done=0, cpu_hold=1.
REQ-033 start; length 0x00 -> ERR next cycle, no pm_we; length 0x21 (33) -> ERR, no pm_we.
REQ-034 TIMEOUT_CYCLES=4, start, length 0x02, one data byte, then rx_valid=0 for 4 cycles -> ERR, load_count=1, one pm_we.
REQ-035 Assert reset during DATA after 2 of 5 bytes -> all outputs at reset values next cycle; subsequent rx_valid ignored until start.
REQ-036 start pulsed during DATA and rx_valid held high with gaps (rx_valid toggling) -> start ignored, load completes normally, one write per accepted byte only.
